// File: rtl/game_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// game_ctrl_fsm
// Level/lives/timer controller for a frog-crossing game. A game starts in
// READY, counts down READY_TICKS ticks, then enters PLAY with PLAY_TICKS ticks
// to reach the final line. Clearing a level advances to the next one. A crash
// or a timeout costs a life. The game ends in WIN after the final level is
// cleared, or in LOSE when no lives remain. WIN and LOSE hold until restart.
//
// Ports
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   tick       in   one-cycle time-base enable
//   hit        in   frog reached final line
//   miss       in   frog crashed
//   restart    in   one-cycle new-game request (WIN/LOSE only)
//   level      out  current level index
//   lives      out  remaining lives
//   game_end   out  00 running, 01 game over, 10 win
//   playing    out  high only in PLAY
//   time_left  out  READY/PLAY countdown, 0 in WIN/LOSE
//   level_up   out  one-cycle pulse on non-final level clear
//   life_lost  out  one-cycle pulse on every life decrement
// ---------------------------------------------------------------------------
module game_ctrl_fsm #(
  parameter int NUM_LEVELS  = 4,
  parameter int NUM_LIVES   = 3,
  parameter int READY_TICKS = 5,
  parameter int PLAY_TICKS  = 30,
  localparam int LVL_W  = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIFE_W = $clog2(NUM_LIVES + 1),
  localparam int TIME_W = $clog2(((READY_TICKS > PLAY_TICKS) ? READY_TICKS : PLAY_TICKS) + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              hit,
  input  logic              miss,
  input  logic              restart,
  output logic [LVL_W-1:0]  level,
  output logic [LIFE_W-1:0] lives,
  output logic [1:0]        game_end,
  output logic              playing,
  output logic [TIME_W-1:0] time_left,
  output logic              level_up,
  output logic              life_lost
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_WIN   = 2'd2;
  localparam logic [1:0] ST_LOSE  = 2'd3;

  localparam logic [1:0] GE_RUN  = 2'b00;
  localparam logic [1:0] GE_OVER = 2'b01;
  localparam logic [1:0] GE_WIN  = 2'b10;

  localparam logic [LVL_W-1:0]  LAST_LVL    = LVL_W'(NUM_LEVELS - 1);
  localparam logic [LVL_W-1:0]  ONE_LVL     = LVL_W'(1);
  localparam logic [LVL_W-1:0]  ZERO_LVL    = {LVL_W{1'b0}};
  localparam logic [LIFE_W-1:0] START_LIVES = LIFE_W'(NUM_LIVES);
  localparam logic [LIFE_W-1:0] ONE_LIFE    = LIFE_W'(1);
  localparam logic [LIFE_W-1:0] ZERO_LIFE   = {LIFE_W{1'b0}};
  localparam logic [TIME_W-1:0] READY_T     = TIME_W'(READY_TICKS);
  localparam logic [TIME_W-1:0] PLAY_T      = TIME_W'(PLAY_TICKS);
  localparam logic [TIME_W-1:0] ONE_T       = TIME_W'(1);
  localparam logic [TIME_W-1:0] ZERO_T      = {TIME_W{1'b0}};

  logic [1:0]        state_r,     state_s;
  logic [LVL_W-1:0]  level_r,     level_s;
  logic [LIFE_W-1:0] lives_r,     lives_s;
  logic [1:0]        game_end_r,  game_end_s;
  logic              playing_r,   playing_s;
  logic [TIME_W-1:0] time_r,      time_s;
  logic              level_up_r,  level_up_s;
  logic              life_lost_r, life_lost_s;

  // Next-state and next-output decode for every state.
  always_comb begin
    state_s     = state_r;
    level_s     = level_r;
    lives_s     = lives_r;
    game_end_s  = game_end_r;
    playing_s   = playing_r;
    time_s      = time_r;
    level_up_s  = 1'b0;
    life_lost_s = 1'b0;
    case (state_r)
      ST_READY: begin
        if (tick) begin
          // <= rather than == so a corrupted zero count cannot wrap
          if (time_r <= ONE_T) begin
            state_s   = ST_PLAY;
            playing_s = 1'b1;
            time_s    = PLAY_T;
          end else begin
            time_s = time_r - ONE_T;
          end
        end else begin
          time_s = time_r;
        end
      end
      ST_PLAY: begin
        // hit wins over miss, which wins over timeout, which wins over decrement
        if (hit) begin
          playing_s = 1'b0;
          if (level_r < LAST_LVL) begin
            level_s    = level_r + ONE_LVL;
            level_up_s = 1'b1;
            state_s    = ST_READY;
            time_s     = READY_T;
          end else begin
            state_s    = ST_WIN;
            game_end_s = GE_WIN;
            time_s     = ZERO_T;
          end
        end else if (miss || (tick && (time_r <= ONE_T))) begin
          life_lost_s = 1'b1;
          playing_s   = 1'b0;
          if (lives_r > ONE_LIFE) begin
            lives_s = lives_r - ONE_LIFE;
            state_s = ST_READY;
            time_s  = READY_T;
          end else begin
            lives_s    = ZERO_LIFE;
            state_s    = ST_LOSE;
            game_end_s = GE_OVER;
            time_s     = ZERO_T;
          end
        end else if (tick) begin
          time_s = time_r - ONE_T;
        end else begin
          time_s = time_r;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (restart) begin
          state_s    = ST_READY;
          level_s    = ZERO_LVL;
          lives_s    = START_LIVES;
          game_end_s = GE_RUN;
          playing_s  = 1'b0;
          time_s     = READY_T;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s    = ST_READY;
        level_s    = ZERO_LVL;
        lives_s    = START_LIVES;
        game_end_s = GE_RUN;
        playing_s  = 1'b0;
        time_s     = READY_T;
      end
    endcase
  end

  // State and output registers; reset loads game-start values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_READY;
      level_r     <= ZERO_LVL;
      lives_r     <= START_LIVES;
      game_end_r  <= GE_RUN;
      playing_r   <= 1'b0;
      time_r      <= READY_T;
      level_up_r  <= 1'b0;
      life_lost_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      level_r     <= level_s;
      lives_r     <= lives_s;
      game_end_r  <= game_end_s;
      playing_r   <= playing_s;
      time_r      <= time_s;
      level_up_r  <= level_up_s;
      life_lost_r <= life_lost_s;
    end
  end

  assign level     = level_r;
  assign lives     = lives_r;
  assign game_end  = game_end_r;
  assign playing   = playing_r;
  assign time_left = time_r;
  assign level_up  = level_up_r;
  assign life_lost = life_lost_r;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_game_ctrl_fsm
// Directed bench for game_ctrl_fsm. Two instances: A with default parameters
// and B with 8 levels / 5 lives / 60 play ticks. The driver applies one input
// vector per cycle on the falling edge and queues the hand-computed expected
// outputs. The monitor pops one entry per cycle after the rising edge and
// compares the selected instance against it.
// ---------------------------------------------------------------------------
module tb_game_ctrl_fsm;

  localparam logic DA = 1'b0;
  localparam logic DB = 1'b1;

  typedef struct packed {
    logic [7:0] lv;
    logic [7:0] lf;
    logic [1:0] ge;
    logic       pl;
    logic [7:0] tl;
    logic       lu;
    logic       ll;
  } exp_t;

  typedef struct packed {
    logic        chk;
    logic        b;
    logic [15:0] id;
    exp_t        x;
  } ent_t;

  logic clk = 1'b0;
  logic reset_a = 1'b0, tick_a = 1'b0, hit_a = 1'b0, miss_a = 1'b0, restart_a = 1'b0;
  logic reset_b = 1'b0, tick_b = 1'b0, hit_b = 1'b0, miss_b = 1'b0, restart_b = 1'b0;

  logic [1:0] level_a;  logic [1:0] lives_a;  logic [1:0] ge_a;
  logic pl_a;  logic [4:0] tl_a;  logic lu_a;  logic ll_a;
  logic [2:0] level_b;  logic [2:0] lives_b;  logic [1:0] ge_b;
  logic pl_b;  logic [5:0] tl_b;  logic lu_b;  logic ll_b;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  always #5 clk = ~clk;

  game_ctrl_fsm dut_a (
    .clk(clk), .reset(reset_a), .tick(tick_a), .hit(hit_a), .miss(miss_a),
    .restart(restart_a), .level(level_a), .lives(lives_a), .game_end(ge_a),
    .playing(pl_a), .time_left(tl_a), .level_up(lu_a), .life_lost(ll_a)
  );

  game_ctrl_fsm #(.NUM_LEVELS(8), .NUM_LIVES(5), .READY_TICKS(5), .PLAY_TICKS(60)) dut_b (
    .clk(clk), .reset(reset_b), .tick(tick_b), .hit(hit_b), .miss(miss_b),
    .restart(restart_b), .level(level_b), .lives(lives_b), .game_end(ge_b),
    .playing(pl_b), .time_left(tl_b), .level_up(lu_b), .life_lost(ll_b)
  );

  function automatic exp_t e(input int lv, input int lf, input int ge, input int pl,
                             input int tl, input int lu, input int ll);
    exp_t r;
    r.lv = 8'(lv); r.lf = 8'(lf); r.ge = 2'(ge); r.pl = 1'(pl);
    r.tl = 8'(tl); r.lu = 1'(lu); r.ll = 1'(ll);
    return r;
  endfunction

  // Monitor: one queue entry per cycle, compared just after the rising edge.
  always @(posedge clk) begin
    ent_t ent;
    exp_t act;
    #1;
    if (q.size() > 0) begin
      ent = q.pop_front();
      if (ent.chk) begin
        if (ent.b == DA)
          act = e(int'(level_a), int'(lives_a), int'(ge_a), int'(pl_a), int'(tl_a), int'(lu_a), int'(ll_a));
        else
          act = e(int'(level_b), int'(lives_b), int'(ge_b), int'(pl_b), int'(tl_b), int'(lu_b), int'(ll_b));
        n_checks++;
        if (act == ent.x) begin
          n_pass++;
        end else begin
          $display("FAIL vec%0d dut%0d actual lv=%0d lf=%0d ge=%0d pl=%0d tl=%0d lu=%0d ll=%0d required lv=%0d lf=%0d ge=%0d pl=%0d tl=%0d lu=%0d ll=%0d",
                   ent.id, ent.b, act.lv, act.lf, act.ge, act.pl, act.tl, act.lu, act.ll,
                   ent.x.lv, ent.x.lf, ent.x.ge, ent.x.pl, ent.x.tl, ent.x.lu, ent.x.ll);
        end
      end
    end
  end

  task automatic step(input logic b, input logic rn, input logic tk, input logic h,
                      input logic m, input logic rs, input logic chk, input exp_t x);
    ent_t ent;
    @(negedge clk);
    if (b == DA) begin
      reset_a = rn; tick_a = tk; hit_a = h; miss_a = m; restart_a = rs;
      tick_b = 1'b0; hit_b = 1'b0; miss_b = 1'b0; restart_b = 1'b0;
    end else begin
      reset_b = rn; tick_b = tk; hit_b = h; miss_b = m; restart_b = rs;
      tick_a = 1'b0; hit_a = 1'b0; miss_a = 1'b0; restart_a = 1'b0;
    end
    vec_id++;
    ent.chk = chk; ent.b = b; ent.id = 16'(vec_id); ent.x = x;
    q.push_back(ent);
  endtask

  task automatic c(input logic b, input logic tk, input logic h, input logic m,
                   input logic rs, input exp_t x);
    step(b, 1'b1, tk, h, m, rs, 1'b1, x);
  endtask

  task automatic n(input logic b, input logic tk, input logic h, input logic m, input logic rs);
    step(b, 1'b1, tk, h, m, rs, 1'b0, e(0, 0, 0, 0, 0, 0, 0));
  endtask

  // Five READY ticks from time_left=5, last one enters PLAY.
  task automatic to_play(input logic b, input int lv, input int lf, input int pt);
    repeat (4) n(b, 1'b1, 1'b0, 1'b0, 1'b0);
    c(b, 1'b1, 1'b0, 1'b0, 1'b0, e(lv, lf, 0, 1, pt, 0, 0));
  endtask

  // From a fresh PLAY countdown pt, tick down to time_left=1.
  task automatic to_one(input logic b, input int lv, input int lf, input int pt);
    repeat (pt - 2) n(b, 1'b1, 1'b0, 1'b0, 1'b0);
    c(b, 1'b1, 1'b0, 1'b0, 1'b0, e(lv, lf, 0, 1, 1, 0, 0));
  endtask

  initial begin
    // ---------------- instance A, default parameters ----------------
    step(DA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 3, 0, 0, 5, 0, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(0, 3, 0, 0, 5, 0, 0));
    c(DA, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 3, 0, 0, 4, 0, 0));
    repeat (3) n(DA, 1'b1, 1'b0, 1'b0, 1'b0);
    c(DA, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 3, 0, 1, 30, 0, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(0, 3, 0, 1, 30, 0, 0));
    c(DA, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 3, 0, 1, 29, 0, 0));
    c(DA, 1'b0, 1'b1, 1'b0, 1'b0, e(1, 3, 0, 0, 5, 1, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(1, 3, 0, 0, 5, 0, 0));
    c(DA, 1'b0, 1'b1, 1'b1, 1'b1, e(1, 3, 0, 0, 5, 0, 0));
    // timeout at level 1
    to_play(DA, 1, 3, 30);
    to_one(DA, 1, 3, 30);
    c(DA, 1'b1, 1'b0, 1'b0, 1'b0, e(1, 2, 0, 0, 5, 0, 1));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(1, 2, 0, 0, 5, 0, 0));
    // hit+miss+tick at time_left=1 counts as hit
    to_play(DA, 1, 2, 30);
    to_one(DA, 1, 2, 30);
    c(DA, 1'b1, 1'b1, 1'b1, 1'b0, e(2, 2, 0, 0, 5, 1, 0));
    to_play(DA, 2, 2, 30);
    c(DA, 1'b0, 1'b1, 1'b0, 1'b0, e(3, 2, 0, 0, 5, 1, 0));
    to_play(DA, 3, 2, 30);
    c(DA, 1'b0, 1'b0, 1'b1, 1'b0, e(3, 1, 0, 0, 5, 0, 1));
    to_play(DA, 3, 1, 30);
    // final level clear
    c(DA, 1'b0, 1'b1, 1'b0, 1'b0, e(3, 1, 2, 0, 0, 0, 0));
    c(DA, 1'b1, 1'b1, 1'b1, 1'b0, e(3, 1, 2, 0, 0, 0, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(3, 1, 2, 0, 0, 0, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 3, 0, 0, 5, 0, 0));
    // three misses to game over
    to_play(DA, 0, 3, 30);
    c(DA, 1'b0, 1'b0, 1'b1, 1'b0, e(0, 2, 0, 0, 5, 0, 1));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(0, 2, 0, 0, 5, 0, 0));
    to_play(DA, 0, 2, 30);
    c(DA, 1'b0, 1'b0, 1'b1, 1'b0, e(0, 1, 0, 0, 5, 0, 1));
    to_play(DA, 0, 1, 30);
    c(DA, 1'b0, 1'b0, 1'b1, 1'b0, e(0, 0, 1, 0, 0, 0, 1));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b0, e(0, 0, 1, 0, 0, 0, 0));
    c(DA, 1'b1, 1'b1, 1'b1, 1'b0, e(0, 0, 1, 0, 0, 0, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 3, 0, 0, 5, 0, 0));
    c(DA, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 3, 0, 0, 5, 0, 0));
    c(DA, 1'b1, 1'b0, 1'b0, 1'b1, e(0, 3, 0, 0, 4, 0, 0));

    // ---------------- instance B, 8 levels / 5 lives / 60 ticks ----------------
    step(DB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 5, 0, 0, 5, 0, 0));
    to_play(DB, 0, 5, 60);
    for (int lv = 0; lv < 4; lv++) begin
      c(DB, 1'b0, 1'b1, 1'b0, 1'b0, e(lv + 1, 5, 0, 0, 5, 1, 0));
      to_play(DB, lv + 1, 5, 60);
    end
    c(DB, 1'b1, 1'b0, 1'b0, 1'b0, e(4, 5, 0, 1, 59, 0, 0));
    // reset mid-PLAY, tick held high must not count
    step(DB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e(0, 5, 0, 0, 5, 0, 0));
    c(DB, 1'b1, 1'b0, 1'b0, 1'b0, e(0, 5, 0, 0, 4, 0, 0));
    n(DB, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL queue_drain actual %0d entries left required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
